wbs_mem_arbiter: RTL
====================

// Module: wbs_mem_arbiter
// PURPOSE
//  Wishbone-slave controller between the Caravel bus and the kd-tree accelerator.
//  Decodes CSR and memory windows, pairs 32-bit halves into 64-bit leaf/query SRAM writes,
//  and sequences best-array SRAM reads. Generates the fsm_start pulse and blocks bus access to
//  shared SRAMs while the search FSM owns them.
// PARAMETERS
//  DATA_WIDTH  11   width of one patch element / index
//  LEAF_AW     9    leaf SRAM word address width (64 leaves x 8 patches)
//  QUERY_AW    9    query SRAM word address width (>= NUM_QUERYS=494)
//  BEST_AW     9    best-array SRAM word address width
//  NODE_AW     6    internal-node index width (63 nodes)
// PORTS
//  wb_clk_i     in   1     sole clock
//  rst_n        in   1     synchronous active-low reset
//  wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe/cycle/write
//  wbs_sel_i    in   4     byte selects; all-ones required, others treated as all-ones
//  wbs_adr_i    in   32    byte address;  wbs_dat_i in 32 write data
//  wbs_ack_o    out  1     one-cycle ack;  wbs_dat_o out 32 read data
//  mem_wdata    out  64    {upper,lower} merged write word (node: [21:0] only)
//  mem_waddr    out  9     word address for leaf/query/node write
//  leaf_we, query_we, node_we  out  1  one-cycle write strobes
//  best_csb     out  1     best SRAM chip select, active-low;  best_addr out BEST_AW
//  best_rdata   in   DATA_WIDTH  best SRAM read data, valid cycle after csb low
//  fsm_start    out  1     one-cycle start pulse;  fsm_busy in 1;  fsm_done in 1
//  mode, debug  out  1     CSR bit 0 values
// BEHAVIOUR
//  Decode adr[31:16]: 0x3000 CSR, 0x3001 query, 0x3002 leaf, 0x3003 best, 0x3004 node; else ack, rd 0.
//  CSR offsets: 0x00 MODE rw, 0x04 DEBUG rw (rd bit31 = sticky ERR), 0x08 DONE ro, 0x0C START wo, 0x10 BUSY ro.
//  FSM: IDLE -> {REG, WR_LO, WR_HI, NODE_WR, RD_REQ -> RD_WAIT} -> ACK -> IDLE. Transaction accepted in IDLE when cyc&stb.
//  Latency: CSR/write ack 2 cycles after accept; best read ack 3 cycles (csb low 1 cycle, capture, ack).
//  ACK returns to IDLE; master may hold stb and change address -> next access accepted immediately (back-to-back).
//  Leaf/query: word = adr[15:3]; adr[2]=0 latches lower half + lo_valid, no SRAM write;
//   adr[2]=1 pulses *_we with {dat_i, lo_buf}, clears lo_valid. Upper with lo_valid=0 -> lower=0, set ERR.
//  Node: index = adr[NODE_AW+1:2]; single write, node_we pulse, mem_wdata[21:0]=dat_i[21:0], rest 0.
//  Best read: adr[2]=0 returns {21'b0, best_rdata}; adr[2]=1 returns 0 without SRAM access.
//  START write: fsm_start high exactly one cycle, clears DONE; ignored (ERR set) if fsm_busy=1.
//  DONE sticky-set on fsm_done; start and done same cycle -> DONE cleared (start wins).
//  fsm_busy=1: leaf/query/node/best accesses acked, write dropped, read returns 0, ERR set. CSRs unaffected.
//  ERR cleared only by writing DEBUG with dat_i[31]=1.
//  Reset: all outputs 0 except best_csb=1; state IDLE, lo_valid=0, DONE=0, ERR=0; reset mid-transaction -> no ack.
// CONFIGURATION
//  WBS_ARB_PERF_EN defined: 32-bit counter of fsm_busy cycles, cleared on fsm_start, saturates at all-ones,
//   readable at CSR 0x14. Undefined: counter absent, 0x14 reads 0, writes ignored.
// STRUCTURE
//  Package fieldious_wbs_pkg: region base/mask constants, CSR offsets, arbiter state enum.
//  Sub-module wbs_csr_regs: MODE/DEBUG/DONE/ERR/perf counter storage and readback mux.
// TESTING
//  Write leaf 0x3002_0008=0x1234_5678 then 0x3002_000C=0x0000_ABCD -> one leaf_we, addr 1, wdata 0x0000ABCD_12345678.
//  Write node 0x3004_0004=0x0037_0801 -> node_we, mem_waddr 1, mem_wdata[21:0]=0x370801; ack 2 cycles after accept.
//  Read 0x3003_0010 with best_rdata=11'd300 -> best_csb low 1 cycle, best_addr 2, wbs_dat_o=300 on ack.
//  Write START then pulse fsm_done -> fsm_start 1 cycle; DONE reads 0 before, 1 after; read of 0x3000_0008 = 1.
//  fsm_busy=1, write query 0x3001_0004 -> ack, no query_we, DEBUG read bit31=1; DEBUG write 0x8000_0000 clears it.
//  Assert rst_n low during RD_WAIT -> no ack, best_csb=1 next cycle, lo_valid=0.

Source files
------------

// File: rtl/fieldious_wbs_pkg.sv
// Shared constants for the kd-tree Wishbone slave: address windows, CSR offsets,
// arbiter states and the window decoder.
package fieldious_wbs_pkg;

    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_LEAF_AW    = 9;
    localparam int DEF_QUERY_AW   = 9;
    localparam int DEF_BEST_AW    = 9;
    localparam int DEF_NODE_AW    = 6;
    localparam int WADDR_W        = 9;

    localparam logic [31:0] REGION_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] REGION_CSR   = 32'h3000_0000;
    localparam logic [31:0] REGION_QUERY = 32'h3001_0000;
    localparam logic [31:0] REGION_LEAF  = 32'h3002_0000;
    localparam logic [31:0] REGION_BEST  = 32'h3003_0000;
    localparam logic [31:0] REGION_NODE  = 32'h3004_0000;

    localparam logic [15:0] CSR_MODE  = 16'h0000;
    localparam logic [15:0] CSR_DEBUG = 16'h0004;
    localparam logic [15:0] CSR_DONE  = 16'h0008;
    localparam logic [15:0] CSR_START = 16'h000C;
    localparam logic [15:0] CSR_BUSY  = 16'h0010;
    localparam logic [15:0] CSR_PERF  = 16'h0014;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_WR_LO,
        ST_WR_HI,
        ST_NODE_WR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_ACK
    } arb_state_t;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_CSR,
        RGN_QUERY,
        RGN_LEAF,
        RGN_BEST,
        RGN_NODE
    } region_t;

    function automatic region_t decode_region(input logic [31:0] adr);
        logic [31:0] base;
        base = adr & REGION_MASK;
        case (base)
            REGION_CSR:   return RGN_CSR;
            REGION_QUERY: return RGN_QUERY;
            REGION_LEAF:  return RGN_LEAF;
            REGION_BEST:  return RGN_BEST;
            REGION_NODE:  return RGN_NODE;
            default:      return RGN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wbs_csr_regs.sv
// MODE/DEBUG/DONE/ERR storage and CSR readback mux for the kd-tree Wishbone slave.
// WBS_ARB_PERF_EN adds a saturating fsm_busy cycle counter at offset 0x14.
module wbs_csr_regs
    import fieldious_wbs_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstN,
    input  logic        i_wrEn,
    input  logic [15:0] i_offset,
    input  logic        i_wrBit0,
    input  logic        i_wrErrClr,
    input  logic        i_fsmStart,
    input  logic        i_fsmDone,
    input  logic        i_fsmBusy,
    input  logic        i_errSet,
    output logic [31:0] o_rdata,
    output logic        o_mode,
    output logic        o_debug
);

    logic r_mode;
    logic r_debug;
    logic r_done;
    logic r_err;

    // A new error report takes priority over a simultaneous software clear.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_mode  <= 1'b0;
            r_debug <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (i_wrEn && i_offset == CSR_MODE)
                r_mode <= i_wrBit0;
            if (i_wrEn && i_offset == CSR_DEBUG)
                r_debug <= i_wrBit0;
            if (i_fsmStart)
                r_done <= 1'b0;
            else if (i_fsmDone)
                r_done <= 1'b1;
            if (i_errSet)
                r_err <= 1'b1;
            else if (i_wrEn && i_offset == CSR_DEBUG && i_wrErrClr)
                r_err <= 1'b0;
        end
    end

`ifdef WBS_ARB_PERF_EN
    logic [31:0] r_perfCnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstN)
            r_perfCnt <= '0;
        else if (i_fsmStart)
            r_perfCnt <= '0;
        else if (i_fsmBusy && r_perfCnt != 32'hFFFF_FFFF)
            r_perfCnt <= r_perfCnt + 32'd1;
    end
`endif

    always_comb begin
        o_rdata = '0;
        case (i_offset)
            CSR_MODE:  o_rdata = {31'b0, r_mode};
            CSR_DEBUG: o_rdata = {r_err, 30'b0, r_debug};
            CSR_DONE:  o_rdata = {31'b0, r_done};
            CSR_BUSY:  o_rdata = {31'b0, i_fsmBusy};
`ifdef WBS_ARB_PERF_EN
            CSR_PERF:  o_rdata = r_perfCnt;
`endif
            default:   o_rdata = '0;
        endcase
    end

    assign o_mode  = r_mode;
    assign o_debug = r_debug;

endmodule

// File: rtl/wbs_mem_arbiter.sv
// Wishbone slave between Caravel and the kd-tree accelerator: CSR/SRAM window decode,
// 64-bit write pairing, best-array reads, search FSM start. Optional macro: WBS_ARB_PERF_EN.
module wbs_mem_arbiter
    import fieldious_wbs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAF_AW    = DEF_LEAF_AW,
    parameter int QUERY_AW   = DEF_QUERY_AW,
    parameter int BEST_AW    = DEF_BEST_AW,
    parameter int NODE_AW    = DEF_NODE_AW
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [63:0]           mem_wdata,
    output logic [WADDR_W-1:0]    mem_waddr,
    output logic                  leaf_we,
    output logic                  query_we,
    output logic                  node_we,
    output logic                  best_csb,
    output logic [BEST_AW-1:0]    best_addr,
    input  logic [DATA_WIDTH-1:0] best_rdata,
    output logic                  fsm_start,
    input  logic                  fsm_busy,
    input  logic                  fsm_done,
    output logic                  mode,
    output logic                  debug
);

    arb_state_t         r_state;
    region_t            r_region;
    logic [15:0]        r_off;
    logic [31:0]        r_dat;
    logic               r_we;
    logic               r_blocked;
    logic [31:0]        r_loBuf;
    logic               r_loValid;
    logic               r_errSet;
    logic               r_ack;
    logic [31:0]        r_datO;
    logic [63:0]        r_memWdata;
    logic [WADDR_W-1:0] r_memWaddr;
    logic               r_leafWe;
    logic               r_queryWe;
    logic               r_nodeWe;
    logic               r_bestCsb;
    logic [BEST_AW-1:0] r_bestAddr;
    logic               r_fsmStart;

    region_t     w_region;
    logic        w_shared;
    logic        w_accept;
    logic        w_csrWr;
    logic [31:0] w_csrRdata;

    // Partial byte selects behave exactly like a full-word access.
    assign w_accept = wbs_cyc_i & wbs_stb_i & (|{wbs_sel_i, 1'b1});
    assign w_region = decode_region(wbs_adr_i);
    assign w_shared = (w_region == RGN_LEAF) || (w_region == RGN_QUERY) ||
                      (w_region == RGN_BEST) || (w_region == RGN_NODE);
    assign w_csrWr  = (r_state == ST_REG) && (r_region == RGN_CSR) && r_we;

    wbs_csr_regs u_csr (
        .i_clk      (wb_clk_i),
        .i_rstN     (rst_n),
        .i_wrEn     (w_csrWr),
        .i_offset   (r_off),
        .i_wrBit0   (r_dat[0]),
        .i_wrErrClr (r_dat[31]),
        .i_fsmStart (r_fsmStart),
        .i_fsmDone  (fsm_done),
        .i_fsmBusy  (fsm_busy),
        .i_errSet   (r_errSet),
        .o_rdata    (w_csrRdata),
        .o_mode     (mode),
        .o_debug    (debug)
    );

    // Busy ownership is sampled at accept so every path keeps its normal ack latency.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_region   <= RGN_NONE;
            r_off      <= '0;
            r_dat      <= '0;
            r_we       <= 1'b0;
            r_blocked  <= 1'b0;
            r_loBuf    <= '0;
            r_loValid  <= 1'b0;
            r_errSet   <= 1'b0;
            r_ack      <= 1'b0;
            r_datO     <= '0;
            r_memWdata <= '0;
            r_memWaddr <= '0;
            r_leafWe   <= 1'b0;
            r_queryWe  <= 1'b0;
            r_nodeWe   <= 1'b0;
            r_bestCsb  <= 1'b1;
            r_bestAddr <= '0;
            r_fsmStart <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_leafWe   <= 1'b0;
            r_queryWe  <= 1'b0;
            r_nodeWe   <= 1'b0;
            r_fsmStart <= 1'b0;
            r_errSet   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_off     <= wbs_adr_i[15:0];
                        r_dat     <= wbs_dat_i;
                        r_we      <= wbs_we_i;
                        r_region  <= w_region;
                        r_blocked <= w_shared & fsm_busy;
                        if ((w_region == RGN_LEAF || w_region == RGN_QUERY) && wbs_we_i)
                            r_state <= wbs_adr_i[2] ? ST_WR_HI : ST_WR_LO;
                        else if (w_region == RGN_NODE && wbs_we_i)
                            r_state <= ST_NODE_WR;
                        else if (w_region == RGN_BEST && !wbs_we_i) begin
                            r_state    <= ST_RD_REQ;
                            r_bestAddr <= wbs_adr_i[BEST_AW+2:3];
                            r_bestCsb  <= fsm_busy | wbs_adr_i[2];
                        end else
                            r_state <= ST_REG;
                    end
                end
                ST_REG: begin
                    r_datO <= '0;
                    if (r_region == RGN_CSR) begin
                        if (!r_we)
                            r_datO <= w_csrRdata;
                        else if (r_off == CSR_START) begin
                            if (fsm_busy)
                                r_errSet <= 1'b1;
                            else
                                r_fsmStart <= 1'b1;
                        end
                    end else if (r_blocked)
                        r_errSet <= 1'b1;
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_WR_LO: begin
                    if (r_blocked)
                        r_errSet <= 1'b1;
                    else begin
                        r_loBuf   <= r_dat;
                        r_loValid <= 1'b1;
                    end
                    r_datO  <= '0;
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_WR_HI: begin
                    if (r_blocked)
                        r_errSet <= 1'b1;
                    else begin
                        r_memWdata <= {r_dat, (r_loValid ? r_loBuf : 32'h0)};
                        r_loValid  <= 1'b0;
                        if (!r_loValid)
                            r_errSet <= 1'b1;
                        if (r_region == RGN_LEAF) begin
                            r_leafWe   <= 1'b1;
                            r_memWaddr <= WADDR_W'(r_off[LEAF_AW+2:3]);
                        end else begin
                            r_queryWe  <= 1'b1;
                            r_memWaddr <= WADDR_W'(r_off[QUERY_AW+2:3]);
                        end
                    end
                    r_datO  <= '0;
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_NODE_WR: begin
                    if (r_blocked)
                        r_errSet <= 1'b1;
                    else begin
                        r_nodeWe   <= 1'b1;
                        r_memWdata <= 64'(r_dat[21:0]);
                        r_memWaddr <= WADDR_W'(r_off[NODE_AW+1:2]);
                    end
                    r_datO  <= '0;
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_RD_REQ: begin
                    r_bestCsb <= 1'b1;
                    r_state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_datO  <= (r_blocked || r_off[2]) ? 32'h0 : 32'(best_rdata);
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_datO;
    assign mem_wdata = r_memWdata;
    assign mem_waddr = r_memWaddr;
    assign leaf_we   = r_leafWe;
    assign query_we  = r_queryWe;
    assign node_we   = r_nodeWe;
    assign best_csb  = r_bestCsb;
    assign best_addr = r_bestAddr;
    assign fsm_start = r_fsmStart;

endmodule
